// File: rtl/ssp_byte_rx_if.sv
// Byte-stream handshake between the SSP receiver (master) and its consumer (slave).
interface ssp_byte_rx_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_data,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_data,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/ssp_byte_rx.sv
// SSP byte receiver: oversamples the serial link, assembles framed LSB-first bytes
// and buffers them in a small FIFO drained through a valid/ready handshake.
module ssp_byte_rx #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                ck_1356meg,
  input  logic                reset,
  input  logic                ssp_clk,
  input  logic                ssp_frame,
  input  logic                ssp_dout,
  ssp_byte_rx_if.master       byte_if,
  output logic                busy,
  output logic                overflow,
  input  logic                clr_status,
  output logic [7:0]          frame_err_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam ptr_t PTR_ONE  = ptr_t'(1);

  typedef enum logic {
    ST_HUNT,
    ST_SHIFT
  } state_e;

  // Input synchronizers plus the previous synchronized bit clock
  logic sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d, sclk_prev_q, sclk_prev_d;
  logic frame_s1_q, frame_s1_d, frame_s2_q, frame_s2_d;
  logic dout_s1_q, dout_s1_d, dout_s2_q, dout_s2_d;

  // Deserializer
  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sr_q, sr_d;
  logic       busy_q, busy_d;

  // FIFO and status
  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  ptr_t       rd_ptr_q, rd_ptr_d;
  ptr_t       wr_ptr_q, wr_ptr_d;
  cnt_t       count_q, count_d;
  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  logic       ovf_q, ovf_d;
  logic [7:0] ferr_cnt_q, ferr_cnt_d;

  logic       bit_edge;
  logic       byte_done;
  logic       frame_err;
  logic [7:0] done_byte;
  logic       pop;
  logic       push;
  logic       drop;
  logic       fifo_full;
  logic [7:0] ferr_base;

  assign bit_edge = sclk_s2_q & ~sclk_prev_q;

  always_comb begin
    sclk_s1_d   = ssp_clk;
    sclk_s2_d   = sclk_s1_q;
    sclk_prev_d = sclk_s2_q;
    frame_s1_d  = ssp_frame;
    frame_s2_d  = frame_s1_q;
    dout_s1_d   = ssp_dout;
    dout_s2_d   = dout_s1_q;

    state_d   = state_q;
    idx_d     = idx_q;
    sr_d      = sr_q;
    byte_done = 1'b0;
    frame_err = 1'b0;
    done_byte = {dout_s2_q, sr_q[6:0]};

    if (bit_edge) begin
      if (frame_s2_q) begin
        // A frame always restarts assembly, even when it interrupts a byte
        frame_err = (state_q == ST_SHIFT);
        sr_d      = '0;
        sr_d[0]   = dout_s2_q;
        state_d   = ST_SHIFT;
        idx_d     = 3'd1;
      end else if (state_q == ST_SHIFT) begin
        sr_d[idx_q] = dout_s2_q;
        if (idx_q == 3'd7) begin
          byte_done = 1'b1;
          state_d   = ST_HUNT;
          idx_d     = 3'd0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
    end

    busy_d = (state_d == ST_SHIFT);
  end

  always_comb begin
    fifo_full = (count_q == CNT_FULL);
    pop       = valid_q & byte_if.byte_ready;
    push      = byte_done & (~fifo_full | pop);
    drop      = byte_done & fifo_full & ~pop;

    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = done_byte;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end

    // Head byte and valid are registered from next-state values so a pop shows at once
    valid_d = (count_d != '0);
    data_d  = mem_d[rd_ptr_d];

    ovf_d     = (clr_status ? 1'b0 : ovf_q) | drop;
    ferr_base = clr_status ? 8'h00 : ferr_cnt_q;
    ferr_cnt_d = ferr_base;
    if (frame_err && ferr_base != 8'hFF) begin
      ferr_cnt_d = ferr_base + 8'h01;
    end
  end

  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      frame_s1_q  <= 1'b0;
      frame_s2_q  <= 1'b0;
      dout_s1_q   <= 1'b0;
      dout_s2_q   <= 1'b0;
      state_q     <= ST_HUNT;
      idx_q       <= '0;
      sr_q        <= '0;
      busy_q      <= 1'b0;
      mem_q       <= '{default: '0};
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      ovf_q       <= 1'b0;
      ferr_cnt_q  <= '0;
    end else begin
      sclk_s1_q   <= sclk_s1_d;
      sclk_s2_q   <= sclk_s2_d;
      sclk_prev_q <= sclk_prev_d;
      frame_s1_q  <= frame_s1_d;
      frame_s2_q  <= frame_s2_d;
      dout_s1_q   <= dout_s1_d;
      dout_s2_q   <= dout_s2_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      sr_q        <= sr_d;
      busy_q      <= busy_d;
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      ovf_q       <= ovf_d;
      ferr_cnt_q  <= ferr_cnt_d;
    end
  end

  assign byte_if.byte_data  = data_q;
  assign byte_if.byte_valid = valid_q;
  assign busy               = busy_q;
  assign overflow           = ovf_q;
  assign frame_err_cnt      = ferr_cnt_q;

endmodule

// File: tb/tb_ssp_byte_rx.sv
// Scoreboard bench for ssp_byte_rx: a bit-queue protocol model predicts bytes and status.
module tb_ssp_byte_rx;
  localparam int unsigned DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       ssp_clk;
  logic       ssp_frame;
  logic       ssp_dout;
  logic       busy;
  logic       overflow;
  logic       clr_status;
  logic [7:0] frame_err_cnt;

  int   rmode;
  logic rnd_ready;

  int vectors;
  int miscompares;

  bit         model_bits[$];
  logic [7:0] exp_q[$];
  int         exp_ferr;
  bit         exp_ovf;

  ssp_byte_rx_if bif();

  assign bif.byte_ready = (rmode == 1) || (rmode == 2 && rnd_ready);

  ssp_byte_rx #(.DEPTH(DEPTH)) dut (
    .ck_1356meg   (clk),
    .reset        (reset),
    .ssp_clk      (ssp_clk),
    .ssp_frame    (ssp_frame),
    .ssp_dout     (ssp_dout),
    .byte_if      (bif),
    .busy         (busy),
    .overflow     (overflow),
    .clr_status   (clr_status),
    .frame_err_cnt(frame_err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rnd_ready = 1'b0;
    forever begin
      @(negedge clk);
      rnd_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  // Monitor: every accepted byte must match the head of the expected queue
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && bif.byte_valid && bif.byte_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL pop_unexpected: got %02h, required no byte", bif.byte_data);
        end else begin
          e = exp_q.pop_front();
          if (bif.byte_data !== e) begin
            miscompares++;
            $display("FAIL pop_data: got %02h, required %02h", bif.byte_data, e);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Protocol model: a frame starts a fresh bit list, eight collected bits form a byte
  task automatic model_bit(input bit fr, input bit d, input bit coincident_pop);
    logic [7:0] b;
    if (fr) begin
      if (model_bits.size() > 0 && exp_ferr < 255) exp_ferr++;
      model_bits.delete();
      model_bits.push_back(d);
    end else if (model_bits.size() > 0) begin
      model_bits.push_back(d);
    end
    if (model_bits.size() == 8) begin
      b = '0;
      for (int i = 0; i < 8; i++) b = b | (8'(model_bits[i]) << i);
      model_bits.delete();
      if (exp_q.size() >= DEPTH && !coincident_pop) exp_ovf = 1'b1;
      else exp_q.push_back(b);
    end
  endtask

  // mode 1: check valid/busy latency around the push; mode 2: ready only in the push cycle
  task automatic send_bit(input bit fr, input bit d, input int half, input int mode);
    ssp_frame = fr;
    ssp_dout  = d;
    model_bit(fr, d, mode == 2);
    ssp_clk = 1'b1;
    for (int i = 0; i < half; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (mode == 1 && i == 1) begin
        #2;
        check("latency_valid_before_push", 32'(bif.byte_valid), 32'd0);
        check("latency_busy_before_push", 32'(busy), 32'd1);
      end
      if (mode == 1 && i == 2) begin
        #2;
        check("latency_valid_at_push", 32'(bif.byte_valid), 32'd1);
        check("latency_busy_after_bit7", 32'(busy), 32'd0);
      end
      if (mode == 2 && i == 1) rmode = 1;
      if (mode == 2 && i == 2) rmode = 0;
    end
    ssp_clk = 1'b0;
    for (int i = 0; i < half; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int half, input int last_mode);
    logic [7:0] v;
    v = b;
    send_bit(1'b1, v[0], half, 0);
    for (int i = 1; i < 7; i++) send_bit(1'b0, v[i], half, 0);
    send_bit(1'b0, v[7], half, last_mode);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_status(input string tag);
    idle(4);
    check({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    check({tag, "_frame_err_cnt"}, 32'(frame_err_cnt), 32'(exp_ferr));
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_status = 1'b0;
    exp_ferr = 0;
    exp_ovf  = 1'b0;
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    model_bits.delete();
    exp_q.delete();
    exp_ferr = 0;
    exp_ovf  = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i >= 1) begin
        check("reset_valid", 32'(bif.byte_valid), 32'd0);
        check("reset_data", 32'(bif.byte_data), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_frame_err_cnt", 32'(frame_err_cnt), 32'd0);
      end
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic drain(input string tag);
    int n;
    rmode = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain_timeout: %0d bytes still expected, required 0", tag, exp_q.size());
    end
    idle(3);
    check({tag, "_empty_after_drain"}, 32'(bif.byte_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    int         half;
    int         k;
    vectors     = 0;
    miscompares = 0;
    rmode       = 0;
    ssp_clk     = 1'b0;
    ssp_frame   = 1'b0;
    ssp_dout    = 1'b0;
    clr_status  = 1'b0;
    reset       = 1'b1;
    @(negedge clk);
    apply_reset(4);

    // Single byte with latency checks
    rmode = 1;
    send_byte(8'hA5, 3, 1);
    drain("single");
    check_status("single");

    // Overflow: five frames into a four-entry FIFO with no consumer
    rmode = 0;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 3, 0);
    check_status("overflow");
    check("overflow_valid", 32'(bif.byte_valid), 32'd1);
    pulse_clr();
    check_status("overflow_clr");

    // Full FIFO with a pop coinciding with the push
    send_byte(8'h66, 3, 2);
    check_status("full_pushpop");
    drain("full_pushpop");

    // Framing error: three bits of an interrupted frame, then a full byte
    rmode = 1;
    send_bit(1'b1, 1'b1, 3, 0);
    send_bit(1'b0, 1'b0, 3, 0);
    send_bit(1'b0, 1'b1, 3, 0);
    send_byte(8'h3C, 3, 0);
    drain("frame_err");
    check_status("frame_err");
    pulse_clr();
    check_status("frame_err_clr");

    // Unframed bits are ignored and keep busy low
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b0, 1'(i & 1), 2, 0);
      check("unframed_busy", 32'(busy), 32'd0);
    end
    send_byte(8'hFF, 2, 0);
    drain("unframed");
    check_status("unframed");

    // Reset after bit 4 discards the partial byte
    send_bit(1'b1, 1'b1, 3, 0);
    for (int i = 1; i <= 4; i++) send_bit(1'b0, 1'b1, 3, 0);
    check("midbyte_busy", 32'(busy), 32'd1);
    apply_reset(3);
    rmode = 1;
    send_byte(8'h81, 3, 0);
    drain("after_reset");
    check_status("after_reset");

    // Randomized traffic with random consumer stalls and interrupted frames
    rmode = 2;
    for (int n = 0; n < 40; n++) begin
      half = int'($urandom_range(2, 4));
      if ($urandom_range(0, 4) == 0) begin
        k = int'($urandom_range(1, 7));
        send_bit(1'b1, 1'($urandom_range(0, 1)), half, 0);
        for (int i = 1; i < k; i++) send_bit(1'b0, 1'($urandom_range(0, 1)), half, 0);
      end
      if ($urandom_range(0, 5) == 0) begin
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'($urandom_range(0, 1)), half, 0);
      end
      b = 8'($urandom_range(0, 255));
      send_byte(b, half, 0);
    end
    drain("random");
    check_status("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ssp_byte_rx.md
# ssp_byte_rx

Receive side of the SSP byte link used by the high-frequency modes. The transmit side shifts one 8-bit value per frame, LSB first, with `ssp_frame` high during bit 0. This block recovers those bytes inside the FPGA's `ck_1356meg` domain: it oversamples the serial lines, detects frame and bit boundaries, assembles bytes, and buffers them in a small FIFO. Downstream logic drains the FIFO through a valid/ready handshake; framing errors and overflow are reported as status.

## Interface
- `DEPTH`, default 4: number of FIFO entries; must be a power of 2, 2..16.
- `ck_1356meg`, input, 1: system clock; all logic is on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `ssp_clk`, input, 1: serial bit clock, asynchronous to `ck_1356meg`; each half-period is at least 2 `ck_1356meg` cycles.
- `ssp_frame`, input, 1: frame marker, high while bit 0 is presented.
- `ssp_dout`, input, 1: serial data, LSB first.
- `byte_data`, output, 8: head-of-FIFO byte.
- `byte_valid`, output, 1: FIFO not empty.
- `byte_ready`, input, 1: consumer accepts `byte_data` in any cycle where `byte_valid && byte_ready`.
- `busy`, output, 1: a byte is partially received (bit index 1..7).
- `overflow`, output, 1: sticky flag; a completed byte was dropped because the FIFO was full.
- `clr_status`, input, 1: single-cycle pulse that clears `overflow` and `frame_err_cnt`.
- `frame_err_cnt`, output, 8: saturating count of frames that arrived mid-byte.

## Operation
- **Input sampling.** `ssp_clk`, `ssp_frame` and `ssp_dout` each pass through a 2-flop synchronizer. A third register holds the previous synchronized `ssp_clk`.
- **Edge detect.** The `edge` strobe is true for one cycle when synchronized `ssp_clk` is 1 and its previous value is 0. Data and frame are taken from their synchronized values in that same cycle.
- **States.**
  - HUNT: waiting for a frame.
  - SHIFT(n), n = 1..7: the next bit to capture is bit n.
- **HUNT.**
  - `edge && frame`: capture bit 0 into `sr[0]`, go to SHIFT(1).
  - `edge && !frame`: ignore the bit.
- **SHIFT(n), `edge && !frame`.**
  - Capture bit n into `sr[n]`.
  - If n < 7, go to SHIFT(n+1).
  - If n = 7, push the assembled byte to the FIFO and go to HUNT.
- **SHIFT(n), `edge && frame`.** This is a framing error.
  - Discard the partial byte.
  - Increment `frame_err_cnt`; it saturates at 255.
  - Treat the bit as bit 0 of a new byte: `sr[0]` takes the data value, go to SHIFT(1).
- **`busy`** is 1 in any SHIFT state.
- **FIFO.** Circular buffer with a read pointer, a write pointer, and a count of width log2(DEPTH)+1.
  - Push happens when a byte completes and (count < DEPTH, or a pop occurs in the same cycle).
  - If count == DEPTH and there is no pop in that cycle, the byte is dropped and `overflow` is set to 1.
  - Pop happens when `byte_valid && byte_ready`.
  - Simultaneous push and pop leaves count unchanged; both pointers advance and wrap modulo DEPTH.
- **`byte_data`** always shows the entry at the read pointer. It is stable while `byte_valid && !byte_ready`.
- **`clr_status`.**
  - Clears `overflow` and `frame_err_cnt` at the next clock edge.
  - If a framing error or overflow occurs in the same cycle, the set or increment wins: the counter becomes 1 and `overflow` stays 1.
- **Reset values.**
  - State HUNT, synchronizers 0, shift register 0.
  - Pointers and count 0.
  - `byte_valid` = 0, `byte_data` = 0x00, `busy` = 0, `overflow` = 0, `frame_err_cnt` = 0.
  - Reset mid-byte discards the partial byte and the FIFO contents. The first byte accepted after reset must begin with a frame.

## Timing
- **Latency.** Let T be the `ck_1356meg` edge that first registers the rising `ssp_clk` of bit 7.
  - `edge` is true in the cycle after T+1.
  - The FIFO is written at edge T+2.
  - `byte_valid` is high from edge T+2 onward when the FIFO was previously empty.
- **Throughput.** One bit per `ssp_clk` period; no bubbles between back-to-back frames.
- **`busy`** rises in the cycle after the bit-0 edge cycle and falls in the cycle after the bit-7 edge cycle.
- **Pop visibility.** A pop at edge K updates `byte_data` and `byte_valid` at edge K; they are registered, with no combinational path from `byte_ready`.
- **Supported clock rate.** `ssp_clk` at `ck_1356meg`/4 (half-period 2 cycles) must be received without loss. Faster `ssp_clk` is unsupported.

## Test plan
- **Single byte.** Frame plus bits of 0xA5, LSB first, `byte_ready`=1 → one `byte_valid` pulse with `byte_data`=0xA5, 3 ck edges after bit-7 sampling; `frame_err_cnt`=0.
- **Overflow.** `byte_ready`=0, DEPTH=4, send 5 frames 0x01..0x05 → count 4, `overflow`=1; drain yields 0x01..0x04 in order, then `byte_valid`=0.
- **Push/pop at full.** FIFO full with `byte_ready`=1 in the push cycle of byte 0x66 → no overflow, count stays 4, 0x66 appears as the last byte drained.
- **Framing error.** Frame, 3 bits, then frame plus 8 bits of 0x3C → `frame_err_cnt`=1, single output byte 0x3C. Pulse `clr_status` → counter 0.
- **Unframed bits.** 5 bits without frame, then frame plus 0xFF → only 0xFF emitted, `busy` low during the unframed bits.
- **Reset mid-byte.** Reset after bit 4 of a frame, then frame plus 0x81 → only 0x81 emitted; all outputs read reset values during reset.
